// File: rtl/tcam_mem_ctrl_pkg.sv
// Shared widths, FSM states and the shadow-rule record for the
// TCAM memory sequencing controller.
package tcam_mem_ctrl_pkg;

    localparam int KEY_W      = 28;
    localparam int SUB_W      = 7;
    localparam int BLOCKS     = 4;
    localparam int RULES      = 64;
    localparam int WORD_W     = 32;
    localparam int SEARCH_LAT = 2;

    localparam int IDX_W    = 6;
    localparam int SLOT_W   = 5;
    localparam int BLK_W    = 2;
    localparam int CNT_W    = 11;
    localparam int ADDR_PAD = KEY_W - BLK_W - 1 - SUB_W;

    localparam int INIT_WRITES = BLOCKS * 2 * (1 << SUB_W);
    localparam int UPD_WRITES  = BLOCKS * (1 << SUB_W);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        DRAIN,
        UPDATE
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [KEY_W-1:0] care;
        logic             valid;
    } rule_t;

endpackage

// File: rtl/tcam_mem_ctrl_word_gen.sv
// Builds one 32-bit SRAM word: bit r is set when rule r of the half
// is valid and its block slice accepts sub-key value a.
// Ports: blk, a (sweep position), rules (one half), word (bitmap).
module tcam_word_gen
    import tcam_mem_ctrl_pkg::*;
(
    input  logic [BLK_W-1:0]   blk,
    input  logic [SUB_W-1:0]   a,
    input  rule_t [WORD_W-1:0] rules,
    output logic [WORD_W-1:0]  word
);

    logic [SUB_W-1:0] ks;
    logic [SUB_W-1:0] cs;

    always_comb begin
        word = '0;
        ks   = '0;
        cs   = '0;
        for (int r = 0; r < WORD_W; r++) begin
            ks = rules[r].key[int'(blk)*SUB_W +: SUB_W];
            cs = rules[r].care[int'(blk)*SUB_W +: SUB_W];
            word[r] = rules[r].valid && (((a ^ ks) & cs) == '0);
        end
    end

endmodule

// File: rtl/tcam_mem_ctrl.sv
// Sequencer for the 64x28 TCAM wrapper: clears memory after reset,
// expands rule installs/deletes into 512-word half rewrites, and
// interleaves pipelined searches. Optional hit flag: TCAM_CTRL_HIT_EN.
// Ports: update and search handshakes, result strobe/pma/hit, busy,
// and the SRAM port (csb, web, wmask, addr, wdata, in_pma).
module tcam_mem_ctrl
    import tcam_mem_ctrl_pkg::*;
(
    input  logic              in_clk,
    input  logic              in_rstn,
    input  logic              in_upd_valid,
    output logic              out_upd_ready,
    input  logic [IDX_W-1:0]  in_upd_idx,
    input  logic [KEY_W-1:0]  in_upd_key,
    input  logic [KEY_W-1:0]  in_upd_care,
    input  logic              in_upd_en,
    input  logic              in_srch_valid,
    output logic              out_srch_ready,
    input  logic [KEY_W-1:0]  in_srch_key,
    output logic              out_rslt_valid,
    output logic [IDX_W-1:0]  out_rslt_pma,
    output logic              out_rslt_hit,
    output logic              out_busy,
    output logic              out_csb,
    output logic              out_web,
    output logic [3:0]        out_wmask,
    output logic [KEY_W-1:0]  out_addr,
    output logic [WORD_W-1:0] out_wdata,
    input  logic [IDX_W-1:0]  in_pma
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                rdy;
    logic [SEARCH_LAT:0] vld;
    rule_t [RULES-1:0]   shadow;
    rule_t [WORD_W-1:0]  gen_rules;
    rule_t               new_rule;
    logic                gen_half;
    logic [BLK_W-1:0]    gen_blk;
    logic [SUB_W-1:0]    gen_a;
    logic [WORD_W-1:0]   gen_word;
    logic                upd_acc;
    logic                srch_acc;

    assign out_upd_ready  = rdy;
    assign out_srch_ready = rdy & ~in_upd_valid;
    assign upd_acc        = rdy & in_upd_valid;
    assign srch_acc       = out_srch_ready & in_srch_valid;
    assign out_busy       = (state != IDLE);
    assign out_wmask      = 4'hF;
    assign out_rslt_valid = vld[SEARCH_LAT];
    assign out_rslt_pma   = vld[SEARCH_LAT] ? in_pma : '0;

    assign new_rule.key   = in_upd_key;
    assign new_rule.care  = in_upd_care;
    assign new_rule.valid = in_upd_en;

    // With no drain the first write leaves on the accept edge, so the
    // incoming rule is bypassed into the generator ahead of the table.
    always_comb begin
        gen_half  = upd_acc ? in_upd_idx[IDX_W-1] : idx[IDX_W-1];
        gen_blk   = upd_acc ? '0 : cnt[BLK_W+SUB_W-1:SUB_W];
        gen_a     = upd_acc ? '0 : cnt[SUB_W-1:0];
        gen_rules = gen_half ? shadow[RULES-1:WORD_W]
                             : shadow[WORD_W-1:0];
        if (upd_acc)
            gen_rules[in_upd_idx[SLOT_W-1:0]] = new_rule;
    end

    tcam_word_gen u_word_gen (
        .blk   (gen_blk),
        .a     (gen_a),
        .rules (gen_rules),
        .word  (gen_word)
    );

    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
            state     <= INIT;
            cnt       <= '0;
            idx       <= '0;
            rdy       <= 1'b0;
            vld       <= '0;
            shadow    <= '0;
            out_csb   <= 1'b1;
            out_web   <= 1'b1;
            out_addr  <= '0;
            out_wdata <= '0;
        end else begin
            vld     <= {vld[SEARCH_LAT-1:0], srch_acc};
            out_csb <= 1'b1;
            out_web <= 1'b1;
            unique case (state)
                INIT: begin
                    if (cnt == CNT_W'(INIT_WRITES)) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        out_csb   <= 1'b0;
                        out_web   <= 1'b0;
                        out_addr  <= {{ADDR_PAD{1'b0}}, cnt[9:0]};
                        out_wdata <= '0;
                        cnt       <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (upd_acc) begin
                        shadow[in_upd_idx] <= new_rule;
                        idx <= in_upd_idx;
                        rdy <= 1'b0;
                        if (|vld) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            state     <= UPDATE;
                            out_csb   <= 1'b0;
                            out_web   <= 1'b0;
                            out_addr  <= {{ADDR_PAD{1'b0}}, 2'b00,
                                          in_upd_idx[IDX_W-1], 7'd0};
                            out_wdata <= gen_word;
                            cnt       <= CNT_W'(1);
                        end
                    end else if (srch_acc) begin
                        out_csb  <= 1'b0;
                        out_addr <= in_srch_key;
                    end
                end
                DRAIN: begin
                    if (vld == '0)
                        state <= UPDATE;
                end
                UPDATE: begin
                    if (cnt == CNT_W'(UPD_WRITES)) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        out_csb   <= 1'b0;
                        out_web   <= 1'b0;
                        out_addr  <= {{ADDR_PAD{1'b0}}, cnt[8:7],
                                      idx[IDX_W-1], cnt[6:0]};
                        out_wdata <= gen_word;
                        cnt       <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef TCAM_CTRL_HIT_EN
    logic                hit_now;
    logic [SEARCH_LAT:0] hit_pipe;

    always_comb begin
        hit_now = 1'b0;
        for (int i = 0; i < RULES; i++)
            if (shadow[i].valid &&
                (((in_srch_key ^ shadow[i].key) & shadow[i].care) == '0))
                hit_now = 1'b1;
    end

    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn)
            hit_pipe <= '0;
        else
            hit_pipe <= {hit_pipe[SEARCH_LAT-1:0], srch_acc & hit_now};
    end

    assign out_rslt_hit = vld[SEARCH_LAT] & hit_pipe[SEARCH_LAT];
`else
    assign out_rslt_hit = 1'b1;
`endif

endmodule

// File: tb/tb_tcam_mem_ctrl.sv
// Scoreboard bench for tcam_mem_ctrl with a behavioural TCAM memory
// and a rule-level reference model.
module tb_tcam_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [5:0]  upd_idx = '0;
    logic [27:0] upd_key = '0;
    logic [27:0] upd_care = '0;
    logic        upd_en = 1'b0;
    logic        srch_valid = 1'b0;
    logic        srch_ready;
    logic [27:0] srch_key = '0;
    logic        rslt_valid;
    logic [5:0]  rslt_pma;
    logic        rslt_hit;
    logic        busy;
    logic        csb;
    logic        web;
    logic [3:0]  wmask;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [5:0]  pma_in = '0;

    always #5 clk = ~clk;

    tcam_mem_ctrl dut (
        .in_clk         (clk),
        .in_rstn        (rst_n),
        .in_upd_valid   (upd_valid),
        .out_upd_ready  (upd_ready),
        .in_upd_idx     (upd_idx),
        .in_upd_key     (upd_key),
        .in_upd_care    (upd_care),
        .in_upd_en      (upd_en),
        .in_srch_valid  (srch_valid),
        .out_srch_ready (srch_ready),
        .in_srch_key    (srch_key),
        .out_rslt_valid (rslt_valid),
        .out_rslt_pma   (rslt_pma),
        .out_rslt_hit   (rslt_hit),
        .out_busy       (busy),
        .out_csb        (csb),
        .out_web        (web),
        .out_wmask      (wmask),
        .out_addr       (addr),
        .out_wdata      (wdata),
        .in_pma         (pma_in)
    );

    typedef struct {
        int         cyc;
        bit         hit;
        logic [5:0] pma;
    } exp_t;

    typedef struct {
        logic [27:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t sb_q[$];
    wr_t  wr_q[$];
    exp_t em;
    wr_t  wm;

    logic [27:0] m_key [64];
    logic [27:0] m_care [64];
    bit          m_val [64];
    logic [31:0] mem [4][2][128];
    logic [5:0]  stage = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    bit prev_rdy = 1'b0;
    bit prev_wr = 1'b0;
    bit cur_wr;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: a 64-bit match vector is the AND of each
    // block's word pair; lowest matching rule index wins.
    function automatic logic [5:0] mem_search(input logic [27:0] k);
        logic [63:0] m;
        m = '1;
        for (int b = 0; b < 4; b++)
            m &= {mem[b][1][k[b*7 +: 7]], mem[b][0][k[b*7 +: 7]]};
        for (int i = 0; i < 64; i++)
            if (m[i]) return 6'(i);
        return 6'd0;
    endfunction

    always @(posedge clk) begin
        if (!csb && !web)
            mem[addr[9:8]][addr[7]][addr[6:0]] <= wdata;
        if (!csb && web)
            stage <= mem_search(addr);
        pma_in <= stage;
    end

    function automatic void ref_search(input logic [27:0] k,
                                       output bit h,
                                       output logic [5:0] p);
        h = 1'b0;
        p = '0;
        for (int i = 63; i >= 0; i--)
            if (m_val[i] && (((k ^ m_key[i]) & m_care[i]) == 28'd0)) begin
                h = 1'b1;
                p = 6'(i);
            end
    endfunction

    function automatic void push_init();
        wr_t w;
        for (int i = 0; i < 1024; i++) begin
            w.addr = 28'(i);
            w.data = '0;
            wr_q.push_back(w);
        end
    endfunction

    function automatic void push_sweep(input int h);
        wr_t w;
        int  ri;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 128; a++) begin
                w.addr = 28'(b * 256 + h * 128 + a);
                w.data = '0;
                for (int r = 0; r < 32; r++) begin
                    ri = h * 32 + r;
                    if (m_val[ri] &&
                        (((7'(a) ^ m_key[ri][b*7 +: 7]) &
                          m_care[ri][b*7 +: 7]) == 7'd0))
                        w.data[r] = 1'b1;
                end
                wr_q.push_back(w);
            end
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 64; i++) begin
            m_val[i]  = 1'b0;
            m_key[i]  = '0;
            m_care[i] = '0;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout got=none exp=event", name);
    endtask

    task automatic check_reset_vals();
        chk("rst_csb", 64'(csb), 64'd1);
        chk("rst_web", 64'(web), 64'd1);
        chk("rst_wmask", 64'(wmask), 64'hF);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_upd_ready", 64'(upd_ready), 64'd0);
        chk("rst_srch_ready", 64'(srch_ready), 64'd0);
        chk("rst_rslt_valid", 64'(rslt_valid), 64'd0);
        chk("rst_rslt_pma", 64'(rslt_pma), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
`ifdef TCAM_CTRL_HIT_EN
        chk("rst_rslt_hit", 64'(rslt_hit), 64'd0);
`endif
    endtask

    // Monitor: write stream, result stream and ready return.
    always @(negedge clk) begin
        if (rst_n) begin
            cur_wr = (!csb && !web);
            if (cur_wr) begin
                checks++;
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got=%h/%h exp=none",
                             addr, wdata);
                end else begin
                    wm = wr_q.pop_front();
                    if (addr !== wm.addr || wdata !== wm.data ||
                        !busy || upd_ready || srch_ready ||
                        sb_q.size() != 0) begin
                        errors++;
                        $display("FAIL write got=%h/%h b%0b r%0b%0b pend%0d exp=%h/%h b1 r00 pend0",
                                 addr, wdata, busy, upd_ready, srch_ready,
                                 sb_q.size(), wm.addr, wm.data);
                    end
                end
            end
            if (rslt_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rslt_unexpected got=%0d exp=none",
                             rslt_pma);
                end else begin
                    em = sb_q.pop_front();
                    if (cyc != em.cyc) begin
                        errors++;
                        $display("FAIL rslt_latency got=%0d exp=%0d",
                                 cyc, em.cyc);
                    end
`ifdef TCAM_CTRL_HIT_EN
                    else if (rslt_hit !== em.hit) begin
                        errors++;
                        $display("FAIL rslt_hit got=%0b exp=%0b",
                                 rslt_hit, em.hit);
                    end
`else
                    else if (rslt_hit !== 1'b1) begin
                        errors++;
                        $display("FAIL rslt_hit got=%0b exp=1", rslt_hit);
                    end
`endif
                    else if (em.hit && rslt_pma !== em.pma) begin
                        errors++;
                        $display("FAIL rslt_pma got=%0d exp=%0d",
                                 rslt_pma, em.pma);
                    end
                end
            end
            if (upd_ready && !prev_rdy) begin
                checks++;
                if (!prev_wr || wr_q.size() != 0 || busy) begin
                    errors++;
                    $display("FAIL ready_return got=wr%0b q%0d b%0b exp=wr1 q0 b0",
                             prev_wr, wr_q.size(), busy);
                end
            end
            prev_rdy = upd_ready;
            prev_wr  = cur_wr;
        end else begin
            prev_rdy = 1'b0;
            prev_wr  = 1'b0;
        end
    end

    task automatic do_search(input logic [27:0] k);
        exp_t e;
        bit   h;
        logic [5:0] p;
        @(negedge clk);
        srch_valid = 1'b1;
        srch_key   = k;
        for (int n = 0; n < 4000; n++) begin
            #1;
            if (srch_ready) begin
                ref_search(k, h, p);
                e.cyc = cyc + 3;
                e.hit = h;
                e.pma = p;
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                srch_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        srch_valid = 1'b0;
        timeout("search_accept");
    endtask

    task automatic do_update(input logic [5:0] i, input logic [27:0] k,
                             input logic [27:0] c, input bit en);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_idx   = i;
        upd_key   = k;
        upd_care  = c;
        upd_en    = en;
        for (int n = 0; n < 4000; n++) begin
            #1;
            if (upd_ready) begin
                m_key[i]  = k;
                m_care[i] = c;
                m_val[i]  = en;
                push_sweep(int'(i[5]));
                @(posedge clk);
                #1;
                upd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        upd_valid = 1'b0;
        timeout("update_accept");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #2;
            if (upd_ready && wr_q.size() == 0 && sb_q.size() == 0)
                return;
        end
        timeout("wait_idle");
    endtask

    function automatic logic [27:0] rkey();
        logic [27:0] k;
        for (int b = 0; b < 4; b++)
            k[b*7 +: 7] = 7'($urandom_range(0, 3));
        return k;
    endfunction

    function automatic logic [27:0] rcare();
        logic [27:0] c;
        int s;
        for (int b = 0; b < 4; b++) begin
            s = $urandom_range(0, 3);
            c[b*7 +: 7] = (s == 0) ? 7'h00 : (s == 1) ? 7'h7E : 7'h7F;
        end
        return c;
    endfunction

    int          nz;
    int          base;
    logic [27:0] k37;
    logic [27:0] kx;
    exp_t        e3;
    bit          h3;
    logic [5:0]  p3;

    initial begin
        clear_model();
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_idle();

        // Install rule 5, all sub-keys 5, full care.
        do_update(6'd5, 28'h0A14285, 28'hFFFFFFF, 1'b1);
        wait_idle();
        nz = 0;
        for (int b = 0; b < 4; b++) begin
            chk("rule5_word", 64'(mem[b][0][5]), 64'h20);
            for (int a = 0; a < 128; a++)
                if (a != 5 && mem[b][0][a] != 0) nz++;
        end
        chk("rule5_others_zero", 64'(nz), 64'd0);
        do_search(28'h0A14285);
        wait_idle();

        // Rule 37 ignores block 3.
        k37 = 28'($urandom);
        k37[6:0] = 7'h40;
        do_update(6'd37, k37, 28'h01FFFFF, 1'b1);
        wait_idle();
        nz = 0;
        for (int a = 0; a < 128; a++)
            if (!mem[3][1][a][5]) nz++;
        chk("rule37_blk3_bits", 64'(nz), 64'd0);
        for (int j = 0; j < 3; j++) begin
            kx = {7'($urandom), k37[20:0]};
            do_search(kx);
        end
        wait_idle();

        // Delete rule 5.
        do_update(6'd5, 28'h0A14285, 28'hFFFFFFF, 1'b0);
        wait_idle();
        nz = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 128; a++)
                if (mem[b][0][a] != 0) nz++;
        chk("delete_lower_zero", 64'(nz), 64'd0);
        do_search(28'h0A14285);
        wait_idle();

        // Two searches in flight, then update and search together.
        do_search(28'h0A14285);
        do_search({7'h11, k37[20:0]});
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_idx    = 6'd9;
        upd_key    = 28'h0A14285;
        upd_care   = 28'hFFFFFFF;
        upd_en     = 1'b1;
        srch_valid = 1'b1;
        srch_key   = 28'h0A14285;
        #1;
        chk("arb_srch_ready_low", 64'(srch_ready), 64'd0);
        chk("arb_upd_ready", 64'(upd_ready), 64'd1);
        m_key[9]  = 28'h0A14285;
        m_care[9] = 28'hFFFFFFF;
        m_val[9]  = 1'b1;
        push_sweep(0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            #1;
            if (srch_ready) begin
                ref_search(28'h0A14285, h3, p3);
                chk("arb_ref_pma9", 64'(p3), 64'd9);
                e3.cyc = cyc + 3;
                e3.hit = h3;
                e3.pma = p3;
                sb_q.push_back(e3);
                @(posedge clk);
                #1;
                break;
            end
            if (n == 3999) timeout("arb_search");
        end
        srch_valid = 1'b0;
        wait_idle();

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0)
                do_update(6'($urandom_range(0, 63)), rkey(), rcare(),
                          $urandom_range(0, 3) != 0);
            else
                for (int j = 0; j < $urandom_range(1, 4); j++)
                    do_search(rkey());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of an update sweep.
        base = wr_cnt;
        do_update(6'd40, rkey(), rcare(), 1'b1);
        for (int n = 0; n < 2000; n++) begin
            if (wr_cnt - base >= 200) break;
            @(negedge clk);
            #2;
            if (n == 1999) timeout("mid_sweep");
        end
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        wr_q.delete();
        sb_q.delete();
        clear_model();
        repeat (2) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_idle();
        kx = rkey();
        ref_search(kx, h3, p3);
        chk("post_reset_ref_miss", 64'(h3), 64'd0);
        do_search(kx);
        wait_idle();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("wr_drained", 64'(wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcam_mem_ctrl.md
# tcam_mem_ctrl

Sequencing controller for the 64-rule × 28-bit TCAM memory wrapper: four 7-bit sub-key blocks, each backed by a 32-bit-wide SRAM split into lower (rules 0–31) and upper (rules 32–63) halves. It owns the memory port. It keeps a shadow rule table, expands each ternary rule install or delete into the full per-block SRAM bitmap rewrite, clears the memory after reset, and arbitrates rule updates against a pipelined search stream. It sits between the control-plane or lookup clients and the TCAM memory wrapper.

## Interface
- KEY_W, 28: search key width
- SUB_W, 7: sub-key bits per block
- BLOCKS, 4: number of sub-key blocks
- RULES, 64: rule count
- WORD_W, 32: SRAM word width (rules per half)
- SEARCH_LAT, 2: cycles from the memory search command to a valid in_pma
- in_clk  input  1  clock
- in_rstn  input  1  asynchronous active-low reset
- in_upd_valid / out_upd_ready  in/out  1  update handshake
- in_upd_idx  input  6  rule index
- in_upd_key  input  28  rule key
- in_upd_care  input  28  1 = compare the bit, 0 = don't care
- in_upd_en  input  1  1 = install, 0 = delete
- in_srch_valid / out_srch_ready  in/out  1  search handshake
- in_srch_key  input  28  search key
- out_rslt_valid  output  1  result strobe, one cycle per search
- out_rslt_pma  output  6  matched rule index
- out_rslt_hit  output  1  any valid rule matched
- out_busy  output  1  init or update sweep in progress
- out_csb, out_web  output  1  memory chip-select and write-enable (both active-low)
- out_wmask  output  4  memory byte mask; always 4'hF
- out_addr  output  28  memory address
- out_wdata  output  32  memory write data
- in_pma  input  6  memory priority-encoder output

## Operation
- FSM states: INIT, IDLE, DRAIN, UPDATE.
- **INIT** (entered on reset):
  - 1024 write cycles, outer loop blk 0..3, middle loop half 0..1, inner loop a 0..127.
  - Each cycle: out_addr = {18'b0, blk, half, a}, out_wdata = 0.
  - Then go to IDLE.
- **IDLE**:
  - out_srch_ready = 1 and out_upd_ready = 1.
  - Update has priority. If in_upd_valid is high, the update is accepted: shadow entry idx is written with key, care and valid = en; out_srch_ready drops in the same cycle. Next state is DRAIN if any search is in flight, otherwise UPDATE.
  - Otherwise an accepted search drives, next cycle, one memory cycle: csb = 0, web = 1, addr = key.
- **DRAIN**: wait until the search pipeline is empty, then go to UPDATE.
- **UPDATE**:
  - 512 write cycles over half h = idx[5], outer loop blk 0..3, inner loop a 0..127.
  - out_addr = {18'b0, blk, h, a}.
  - Bit r of out_wdata = valid[h*32+r] && ((a ^ key[blk]) & care[blk]) == 0, where key[blk] and care[blk] are the blk-th 7-bit slices of that rule's stored key and care.
  - Then go to IDLE.
- Delete uses the same sweep with valid cleared.
- Updating an already-valid index overwrites it.
- Memory is idle (csb = 1) in any cycle without a command.
- Search results are returned strictly in order, one per accepted search.

## Timing
- Reset values: out_csb = 1, out_web = 1, out_wmask = 4'hF, out_addr = 0, out_wdata = 0, both readies 0, out_rslt_valid = 0, out_rslt_pma = 0, out_rslt_hit = 0, out_busy = 1, all shadow valid bits = 0.
- Reset mid-sweep: outputs take reset values immediately, the shadow table is cleared, and INIT restarts from address 0.
- Memory outputs are registered. A search accepted at edge t drives the memory command in cycle t+1. out_rslt_valid and out_rslt_pma (= in_pma) follow SEARCH_LAT cycles after that command cycle.
- Search throughput is one per cycle in IDLE. A SEARCH_LAT+1-deep valid shift register tracks in-flight searches.
- Update accepted at edge t: the first write is in cycle t+1 (plus drain time). out_upd_ready returns in the cycle after the 512th write.
- out_busy is high in INIT, DRAIN and UPDATE.

## Configuration
- TCAM_CTRL_HIT_EN defined:
  - At search accept, 64 ternary compares against the shadow table produce a hit flag.
  - The flag is pipelined alongside the search and delivered as out_rslt_hit with out_rslt_valid.
  - out_rslt_hit = 0 means out_rslt_pma is meaningless.
- TCAM_CTRL_HIT_EN undefined: out_rslt_hit is tied to 1 and no compare logic is built.

## Structure
- tcam_mem_ctrl_pkg holds:
  - the width and count localparams;
  - the state enum;
  - the rule struct {key, care, valid};
  - the sweep-counter field widths.
- Sub-module tcam_word_gen (combinational) takes blk, a, and the 32 rules of one half, and returns the 32-bit word.

## Test plan
1. **Reset and init.** Release reset → 1024 writes with wdata = 0, out_busy high throughout → ready in the cycle after the last write; no search accepted before then.
2. **Install and search.** Install rule 5 with all sub-keys 7'b0000101 and care all ones → 512 writes:
   - address {b, 0, 7'b0000101} gets 32'h00000020;
   - all other lower-half addresses get 0.
   
   Then search key 28'h0A14285 → pma = 5, hit = 1, SEARCH_LAT+1 cycles after accept.
3. **Don't-care block.** Install rule 37 with care[27:21] = 0 → every upper-half address of block 3 has bit 5 set. A search matching blocks 0–2, with any block-3 value → pma = 37.
4. **Delete.** Delete rule 5, then repeat the step-2 search → hit = 0 (HIT_EN build); lower-half block words are 0.
5. **Arbitration and drain.** Two searches in flight when an update and a search are both valid → update accepted, search ready low; both in-flight results delivered before the first write; searches after the sweep return correct results.
6. **Reset mid-sweep.** Reset asserted at write 200 of an UPDATE → reset values immediately; INIT sweep reruns; a subsequent search returns hit = 0.
